// File: rtl/ram_burst_reader.sv
// Burst reader for a single-port synchronous RAM: host writes while idle, then streams a
// contiguous burst of words out through a 2-entry skid FIFO with valid/ready handshake.
module ram_burst_reader #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   burst_len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [ADDR_WIDTH:0] LenOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
   logic [ADDR_WIDTH:0]   beat_left_q, beat_left_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            count_q, count_d;
   logic                  wr_idx_q, rd_idx_q;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];

   logic idle, pop, issue, flush, fifo_we;
   logic [2:0] committed;

   assign idle  = (state_q == StIdle);
   assign pop   = m_valid && m_ready;
   assign flush = abort && !idle;
   // Occupancy after this cycle's pop plus the word already on its way from the RAM.
   assign committed = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
   assign issue     = (state_q == StRun) && (committed < 3'd2);
   assign fifo_we   = inflight_q && !flush;

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      issue_left_d = issue_left_q;
      beat_left_d  = beat_left_q;
      done_d       = 1'b0;
      inflight_d   = issue;
      count_d      = count_q + {1'b0, inflight_q} - {1'b0, pop};
      if (pop) begin
         beat_left_d = beat_left_q - LenOne;
      end
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = StRun;
                  rd_ptr_d     = base_addr;
                  issue_left_d = burst_len;
                  beat_left_d  = burst_len;
               end
            end
         end
         StRun: begin
            if (issue) begin
               rd_ptr_d     = rd_ptr_q + 1'b1;
               issue_left_d = issue_left_q - LenOne;
               if (issue_left_q == LenOne) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && m_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d    = StIdle;
         inflight_d = 1'b0;
         count_d    = 2'd0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         rd_ptr_q     <= '0;
         issue_left_q <= '0;
         beat_left_q  <= '0;
         inflight_q   <= 1'b0;
         count_q      <= 2'd0;
         wr_idx_q     <= 1'b0;
         rd_idx_q     <= 1'b0;
         done_q       <= 1'b0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         issue_left_q <= issue_left_d;
         beat_left_q  <= beat_left_d;
         inflight_q   <= inflight_d;
         count_q      <= count_d;
         done_q       <= done_d;
         if (fifo_we) begin
            fifo_q[wr_idx_q] <= ram_dout;
         end
         if (flush) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
         end else begin
            if (fifo_we) wr_idx_q <= ~wr_idx_q;
            if (pop)     rd_idx_q <= ~rd_idx_q;
         end
      end
   end

   assign busy     = !idle;
   assign wr_ready = idle;
   assign done     = done_q;
   assign ram_we   = idle && wr_en && !rst;
   assign ram_addr = idle ? wr_addr : rd_ptr_q;
   assign ram_din  = wr_data;
   assign m_valid  = (count_q != 2'd0);
   assign m_data   = fifo_q[rd_idx_q];
   assign m_last   = m_valid && (beat_left_q == LenOne);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural synchronous RAM attached.
module tb_ram_burst_reader;

   logic        clk = 1'b0;
   logic        rst, start, abort, wr_en, m_ready;
   logic [11:0] base_addr, wr_addr;
   logic [12:0] burst_len;
   logic [7:0]  wr_data;
   logic        busy, done, wr_ready, ram_we, m_valid, m_last;
   logic [11:0] ram_addr;
   logic [7:0]  ram_din, ram_dout, m_data;

   logic [7:0]  ram_mem [0:4095];

   int checks = 0;
   int errors = 0;

   // Burst capture results filled by run_burst.
   logic [7:0]  got_data [0:15];
   logic        got_last [0:15];
   logic [11:0] addr_log [0:15];
   int          got_n, first_valid, last_cyc, done_cycle;
   bit          saw_we, saw_wr_ready, timed_out;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   ram_burst_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .burst_len (burst_len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready)
   );

   task automatic host_write(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Starts a burst with m_ready held high and records beats until done or a 40-cycle bound.
   task automatic run_burst(input logic [11:0] base, input logic [12:0] len, input bit wr_with,
                            input logic [11:0] wa, input logic [7:0] wd, input bit wr_busy);
      @(negedge clk);
      start = 1'b1; base_addr = base; burst_len = len; m_ready = 1'b1;
      if (wr_with) begin
         wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      got_n = 0; first_valid = -1; last_cyc = -1; done_cycle = -1;
      saw_we = 1'b0; saw_wr_ready = 1'b0; timed_out = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc <= 16) addr_log[cyc-1] = ram_addr;
         if (m_valid && got_n < 16) begin
            if (first_valid < 0) first_valid = cyc;
            got_data[got_n] = m_data;
            got_last[got_n] = m_last;
            got_n++;
            if (m_last) last_cyc = cyc;
         end
         wr_en   = wr_busy && busy;
         wr_addr = 12'h021;
         wr_data = 8'hEE;
         #1;
         if (wr_en) begin
            if (ram_we)   saw_we = 1'b1;
            if (wr_ready) saw_wr_ready = 1'b1;
         end
         if (done) begin
            done_cycle = cyc;
            break;
         end
      end
      wr_en = 1'b0;
      if (done_cycle < 0) timed_out = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, m_valid, m_last, ram_we, wr_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_flags got busy/done/valid/last/we/wr_ready=%b want 000001",
                  {busy, done, m_valid, m_last, ram_we, wr_ready});
      end
      checks++;
      if (m_data !== 8'h00) begin
         errors++; $display("FAIL reset_m_data got %h want 00", m_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      for (int i = 0; i < 4; i++) host_write(12'h020 + 12'(i), 8'h10 + 8'(i));
      run_burst(12'h020, 13'd4, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (timed_out || got_n != 4) begin
         errors++; $display("FAIL basic_count got %0d beats (timeout=%0b) want 4", got_n, timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_data[i] !== 8'h10 + 8'(i) || got_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL basic_beat%0d got data=%h last=%b want data=%h last=%b", i,
                     got_data[i], got_last[i], 8'h10 + 8'(i), (i == 3));
         end
      end
      checks++;
      if (first_valid != 3 || last_cyc != 6 || done_cycle != 7) begin
         errors++;
         $display("FAIL basic_timing got first=%0d last=%0d done=%0d want 3 6 7",
                  first_valid, last_cyc, done_cycle);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_wrap;
      host_write(12'hFFE, 8'hA0);
      host_write(12'hFFF, 8'hA1);
      host_write(12'h000, 8'hA2);
      host_write(12'h001, 8'hA3);
      run_burst(12'hFFE, 13'd4, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (timed_out || got_n != 4 || got_data[0] !== 8'hA0 || got_data[1] !== 8'hA1 ||
          got_data[2] !== 8'hA2 || got_data[3] !== 8'hA3) begin
         errors++;
         $display("FAIL wrap_data got n=%0d %h %h %h %h want 4 a0 a1 a2 a3", got_n,
                  got_data[0], got_data[1], got_data[2], got_data[3]);
      end
      checks++;
      if (addr_log[0] !== 12'hFFE || addr_log[1] !== 12'hFFF || addr_log[2] !== 12'h000 ||
          addr_log[3] !== 12'h001) begin
         errors++;
         $display("FAIL wrap_addr got %h %h %h %h want ffe fff 000 001",
                  addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
      end
   endtask

   task automatic test_stall;
      int   got;
      bit   rdy, prev_stall, seen_done;
      logic [7:0]  prev_data;
      logic        prev_last;
      logic [11:0] lead;
      int   bad_order, bad_stable, bad_lead;
      for (int i = 0; i < 6; i++) host_write(12'h040 + 12'(i), 8'h60 + 8'(i));
      @(negedge clk);
      start = 1'b1; base_addr = 12'h040; burst_len = 13'd6; m_ready = 1'b0;
      got = 0; prev_stall = 1'b0; seen_done = 1'b0;
      bad_order = 0; bad_stable = 0; bad_lead = 0;
      prev_data = 8'h00; prev_last = 1'b0;
      for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
            bad_stable++;
         lead = ram_addr - (12'h040 + 12'(got));
         if (busy && lead > 12'd2) bad_lead++;
         rdy = !(cyc >= 3 && cyc <= 7) && cyc != 9 && cyc != 12;
         m_ready = rdy;
         if (m_valid && rdy) begin
            if (m_data !== 8'h60 + 8'(got) || m_last !== (got == 5)) bad_order++;
            got++;
         end
         prev_stall = m_valid && !rdy;
         prev_data  = m_data;
         prev_last  = m_last;
         if (done) seen_done = 1'b1;
      end
      m_ready = 1'b1;
      checks++;
      if (got != 6 || !seen_done) begin
         errors++; $display("FAIL stall_count got %0d beats done=%0b want 6 1", got, seen_done);
      end
      checks++;
      if (bad_order != 0) begin
         errors++; $display("FAIL stall_order got %0d bad beats want 0", bad_order);
      end
      checks++;
      if (bad_stable != 0) begin
         errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad_stable);
      end
      checks++;
      if (bad_lead != 0) begin
         errors++; $display("FAIL stall_lead got %0d cycles leading >2 want 0", bad_lead);
      end
   endtask

   task automatic test_len0_and_write_block;
      run_burst(12'h020, 13'd0, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (got_n != 0 || done_cycle != 1) begin
         errors++; $display("FAIL len0 got beats=%0d done_cycle=%0d want 0 1", got_n, done_cycle);
      end
      run_burst(12'h020, 13'd4, 1'b0, 12'h000, 8'h00, 1'b1);
      checks++;
      if (saw_we || saw_wr_ready) begin
         errors++;
         $display("FAIL busy_write got ram_we=%0b wr_ready=%0b want 0 0", saw_we, saw_wr_ready);
      end
      run_burst(12'h021, 13'd1, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (got_n != 1 || got_data[0] !== 8'h11) begin
         errors++; $display("FAIL busy_write_ram got n=%0d %h want 1 11", got_n, got_data[0]);
      end
   endtask

   task automatic test_start_with_write;
      run_burst(12'h030, 13'd1, 1'b1, 12'h030, 8'h5A, 1'b0);
      checks++;
      if (got_n != 1 || got_data[0] !== 8'h5A || got_last[0] !== 1'b1) begin
         errors++;
         $display("FAIL start_write got n=%0d data=%h last=%b want 1 5a 1",
                  got_n, got_data[0], got_last[0]);
      end
   endtask

   task automatic test_abort;
      int beats, bad;
      @(negedge clk);
      start = 1'b1; base_addr = 12'h020; burst_len = 13'd8; m_ready = 1'b1;
      beats = 0;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 5) abort = 1'b1;
         else if (m_valid) beats++;
      end
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (beats != 2 || {m_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL abort got beats=%0d valid/busy/done=%b want 2 000",
                  beats, {m_valid, busy, done});
      end
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_valid || done || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL abort_quiet got %0d active cycles want 0", bad);
      end
      run_burst(12'h020, 13'd2, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (got_n != 2 || got_data[0] !== 8'h10 || got_data[1] !== 8'h11) begin
         errors++;
         $display("FAIL abort_recover got n=%0d %h %h want 2 10 11", got_n, got_data[0], got_data[1]);
      end
   endtask

   task automatic test_rst_mid;
      int bad;
      @(negedge clk);
      start = 1'b1; base_addr = 12'h020; burst_len = 13'd8; m_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1; start = 1'b1; abort = 1'b1; wr_en = 1'b1; wr_addr = 12'h020; wr_data = 8'h99;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, done, m_valid, m_last, ram_we, wr_ready} !== 6'b000001 || m_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid got busy/done/valid/last/we/wr_ready=%b data=%h want 000001 00",
                  {busy, done, m_valid, m_last, ram_we, wr_ready}, m_data);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_valid || busy || done) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL rst_discard got %0d active cycles want 0", bad);
      end
      run_burst(12'h020, 13'd1, 1'b0, 12'h000, 8'h00, 1'b0);
      checks++;
      if (got_n != 1 || got_data[0] !== 8'h10) begin
         errors++; $display("FAIL rst_no_write got n=%0d %h want 1 10", got_n, got_data[0]);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
      base_addr = '0; burst_len = '0; wr_addr = '0; wr_data = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_len0_and_write_block();
      test_start_with_write();
      test_abort();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
